key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Consumes the level output of one debouncer (1 = key held) and converts it into
//  single-cycle key events for the music player control FSM: press, short release,
//  long-press and auto-repeat (e.g. fast-forward / volume step while held).
//  Uses the same ~1.31 ms en tick that drives the debouncer for all hold timing.
// PARAMETERS
//  CNT_WIDTH     10   width of hold-tick counter; must satisfy 2^CNT_WIDTH >= max(LONG_TICKS,REPEAT_TICKS)
//  LONG_TICKS    762  en ticks held in PRESSED before long_pulse (~1.0 s); >= 1
//  REPEAT_TICKS  153  en ticks between repeat_pulse in LONG (~200 ms); >= 1
//  REPEAT_EN     1    1 = generate repeat_pulse in LONG; 0 = repeat_pulse tied 0
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-low reset
//  en            in   1  1-cycle timing tick (~1.31 ms period)
//  key           in   1  debounced key level, 1 = held
//  press_pulse   out  1  1 cycle on key 0->1
//  short_pulse   out  1  1 cycle on release before long threshold
//  long_pulse    out  1  1 cycle when hold reaches LONG_TICKS
//  repeat_pulse  out  1  1 cycle every REPEAT_TICKS ticks while in LONG
//  held_long     out  1  level, 1 while in LONG
// BEHAVIOUR
//  - One clock domain; all outputs registered. reset low: state=IDLE, cnt=0, all outputs 0.
//  - States (2-bit): IDLE, PRESSED, LONG. Transitions evaluated on each rising clk:
//    IDLE:    key=1 -> PRESSED, cnt<=0, press_pulse=1 next cycle. key=0 -> stay.
//    PRESSED: key=0 -> IDLE, short_pulse=1 next cycle, cnt<=0.
//             key=1 & en & cnt==LONG_TICKS-1 -> LONG, cnt<=0, long_pulse=1 next cycle.
//             key=1 & en (otherwise) -> cnt<=cnt+1. key=1 & ~en -> hold cnt.
//    LONG:    key=0 -> IDLE, cnt<=0, no pulse (long press already reported).
//             key=1 & en & cnt==REPEAT_TICKS-1 -> cnt<=0, repeat_pulse=1 next cycle (if REPEAT_EN).
//             key=1 & en (otherwise) -> cnt<=cnt+1.
//  - Latency: every event pulse appears exactly 1 clk after the sampling edge that caused it.
//  - Pulses are exactly 1 clk wide; at most one of press/short/long/repeat is high per cycle.
//  - Release and en in same cycle: release wins; no long/repeat pulse issued.
//  - Threshold timing counts en ticks seen while key=1, starting with the first en after entry;
//    hold time quantised to +/-1 tick; en in the cycle key first rises is not counted.
//  - cnt never wraps: cleared on every threshold hit and on every state change.
//  - LONG_TICKS=1: first en after press triggers long_pulse.
//  - held_long = (state==LONG), registered, drops 1 clk after key sampled 0.
//  - Illegal state encoding -> IDLE next cycle, outputs 0.
//  - reset asserted mid-hold: immediate return to IDLE, no pulses; after release of reset
//    with key=1, press_pulse issued as a fresh press.
// TESTING (bench params LONG_TICKS=4, REPEAT_TICKS=2, REPEAT_EN=1, en every 4 clks)
//  1 key 0->1 for 2 en ticks then 0 -> press_pulse 1 clk after rise; short_pulse 1 clk after fall; no long.
//  2 key held 10 en ticks -> long_pulse after 4th tick, repeat_pulse after ticks 6,8,10; held_long=1 from long.
//  3 key falls in same cycle as 4th en -> short_pulse only, no long_pulse, state IDLE.
//  4 REPEAT_EN=0, hold 10 ticks -> single long_pulse, repeat_pulse never 1; release -> no short_pulse.
//  5 reset low during LONG with key=1, release reset -> all outputs 0 during reset, then press_pulse once.
//  6 key toggles every clk with en=0 -> alternating press_pulse/short_pulse, never long/repeat.

Source files
------------

// File: rtl/key_event_if.sv
// key_event_if: bundle between the debounced key source and the event decoder.
//   en            1-cycle timing tick shared with the debouncer
//   key           debounced key level, 1 = held
//   press_pulse   1 clk on key 0->1
//   short_pulse   1 clk on release before the long threshold
//   long_pulse    1 clk when the hold reaches the long threshold
//   repeat_pulse  1 clk every repeat interval while long-held
//   held_long     level, 1 while long-held
// master drives en/key and observes events; slave is the decoder.
interface key_event_if;
  logic en;
  logic key;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held_long;

  modport master (
    output en, key,
    input  press_pulse, short_pulse, long_pulse, repeat_pulse, held_long
  );

  modport slave (
    input  en, key,
    output press_pulse, short_pulse, long_pulse, repeat_pulse, held_long
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into single-cycle events
// (press, short release, long press, auto-repeat) for the player control FSM.
// Hold timing counts en ticks while the key is held.
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous, active-low reset
//   bus      key_event_if.slave (en, key in; pulses and held_long out)
// All outputs are registered; each pulse appears 1 clk after the edge that
// sampled its cause.
module key_event_decoder #(
  parameter int CNT_WIDTH    = 10,
  parameter int LONG_TICKS   = 762,
  parameter int REPEAT_TICKS = 153,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  key_event_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_press;
  logic                 r_short;
  logic                 r_long;
  logic                 r_repeat;
  logic                 r_held_long;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_press     <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_held_long <= 1'b0;
    end else begin
      // Pulses default low so each event lasts exactly one clock.
      r_press  <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_held_long <= 1'b0;
          // en in the rising cycle is deliberately not counted.
          if (bus.key) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end
        end
        S_PRESSED: begin
          r_held_long <= 1'b0;
          // Release is checked first so a coincident en cannot raise long.
          if (!bus.key) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
          end else if (bus.en) begin
            if (r_cnt == LONG_LAST) begin
              r_state     <= S_LONG;
              r_cnt       <= '0;
              r_long      <= 1'b1;
              r_held_long <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        S_LONG: begin
          if (!bus.key) begin
            // Long press was already reported; release is silent.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_held_long <= 1'b0;
          end else begin
            r_held_long <= 1'b1;
            if (bus.en) begin
              if (r_cnt == REPEAT_LAST) begin
                r_cnt    <= '0;
                r_repeat <= REPEAT_EN;
              end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
              end
            end
          end
        end
        default: begin
          // Illegal encoding recovers to IDLE with everything quiet.
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_held_long <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse  = r_press;
  assign bus.short_pulse  = r_short;
  assign bus.long_pulse   = r_long;
  assign bus.repeat_pulse = r_repeat;
  assign bus.held_long    = r_held_long;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench: two decoders (repeat enabled / disabled) share key and en.
// Output vectors are {press, short, long, repeat, held_long}.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  key_event_if u_if_a ();
  key_event_if u_if_b ();

  assign u_if_a.key = key;
  assign u_if_a.en  = en;
  assign u_if_b.key = key;
  assign u_if_b.en  = en;

  key_event_decoder #(.CNT_WIDTH(10), .LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_EN(1'b1))
    u_dut_a (.i_clk(clk), .i_reset(rst_n), .bus(u_if_a.slave));
  key_event_decoder #(.CNT_WIDTH(10), .LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_EN(1'b0))
    u_dut_b (.i_clk(clk), .i_reset(rst_n), .bus(u_if_b.slave));

  wire [4:0] out_a = {u_if_a.press_pulse, u_if_a.short_pulse, u_if_a.long_pulse,
                      u_if_a.repeat_pulse, u_if_a.held_long};
  wire [4:0] out_b = {u_if_b.press_pulse, u_if_b.short_pulse, u_if_b.long_pulse,
                      u_if_b.repeat_pulse, u_if_b.held_long};

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] PRESS = 5'b10000;
  localparam logic [4:0] SHORT = 5'b01000;
  localparam logic [4:0] LONGP = 5'b00101;
  localparam logic [4:0] HELD  = 5'b00001;
  localparam logic [4:0] REPT  = 5'b00011;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, sample #1 later and check both DUTs.
  task automatic step(input logic k, input logic e, input logic [4:0] ea,
                      input logic [4:0] eb, input string tag);
    key = k;
    en  = e;
    @(posedge clk);
    #1;
    chk({tag, "_a"}, out_a, ea);
    chk({tag, "_b"}, out_b, eb);
  endtask

  task automatic quiet(input logic k, input int n, input logic [4:0] ea,
                       input logic [4:0] eb, input string tag);
    for (int i = 0; i < n; i++) step(k, 1'b0, ea, eb, tag);
  endtask

  // Press followed by n en ticks (en every 4 clks) with no threshold reached.
  task automatic press_ticks(input int n, input string tag);
    step(1'b1, 1'b0, PRESS, PRESS, {tag, "_press"});
    for (int t = 0; t < n; t++) begin
      quiet(1'b1, 3, NONE, NONE, {tag, "_q"});
      step(1'b1, 1'b1, NONE, NONE, {tag, "_tick"});
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_a", out_a, NONE);
    chk("reset_b", out_b, NONE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet(1'b0, 2, NONE, NONE, "idle");
    step(1'b0, 1'b1, NONE, NONE, "idle_en");

    // 1: short press of 2 ticks
    press_ticks(2, "t1");
    step(1'b0, 1'b0, SHORT, SHORT, "t1_short");
    step(1'b0, 1'b0, NONE, NONE, "t1_after");

    // 2 / 4: hold 10 ticks; long on tick 4, repeat on even ticks after (A only)
    step(1'b1, 1'b0, PRESS, PRESS, "t2_press");
    for (int t = 1; t <= 10; t++) begin
      quiet(1'b1, 3, (t >= 5) ? HELD : NONE, (t >= 5) ? HELD : NONE, "t2_q");
      if (t < 4)       step(1'b1, 1'b1, NONE, NONE, "t2_tick");
      else if (t == 4) step(1'b1, 1'b1, LONGP, LONGP, "t2_long");
      else             step(1'b1, 1'b1, (t % 2 == 0) ? REPT : HELD, HELD, "t2_rep");
    end
    quiet(1'b1, 2, HELD, HELD, "t2_hold");
    step(1'b0, 1'b0, NONE, NONE, "t2_release");
    step(1'b0, 1'b0, NONE, NONE, "t2_after");

    // 3: release coincides with 4th en -> short only
    press_ticks(3, "t3");
    quiet(1'b1, 3, NONE, NONE, "t3_q");
    step(1'b0, 1'b1, SHORT, SHORT, "t3_rel_en");
    step(1'b0, 1'b0, NONE, NONE, "t3_after");

    // en in the rising cycle is not counted: long needs 4 further ticks
    step(1'b1, 1'b1, PRESS, PRESS, "t7_press_en");
    for (int t = 1; t <= 4; t++) begin
      quiet(1'b1, 3, NONE, NONE, "t7_q");
      step(1'b1, 1'b1, (t == 4) ? LONGP : NONE, (t == 4) ? LONGP : NONE, "t7_tick");
    end
    quiet(1'b1, 3, HELD, HELD, "t7_held");

    // 5: reset during LONG with key held, then fresh press
    rst_n = 1'b0;
    #1;
    chk("t5_async_a", out_a, NONE);
    chk("t5_async_b", out_b, NONE);
    quiet(1'b1, 2, NONE, NONE, "t5_in_reset");
    rst_n = 1'b1;
    step(1'b1, 1'b0, PRESS, PRESS, "t5_press");
    quiet(1'b1, 2, NONE, NONE, "t5_hold");
    step(1'b0, 1'b0, SHORT, SHORT, "t5_short");

    // 6: toggle every clk with en=0
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, PRESS, PRESS, "t6_press");
      step(1'b0, 1'b0, SHORT, SHORT, "t6_short");
    end
    step(1'b0, 1'b0, NONE, NONE, "t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
